// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame receiver and the command decoder.
package spi_pkg;

    localparam int SPI_BYTE_W      = 8;
    localparam int FRAME_BYTES_DEF = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        FULL    = 2'd2,
        WAIT_CS = 2'd3
    } spi_state_e;

    // Command byte layout: bit 7 selects write, bits 6:0 address a register.
    localparam int CMD_WR_BIT = 7;
    localparam int CMD_ADDR_W = 7;

    function automatic logic cmd_is_write(input logic [SPI_BYTE_W-1:0] cmd);
        return cmd[CMD_WR_BIT];
    endfunction

    function automatic logic [CMD_ADDR_W-1:0] cmd_addr(input logic [SPI_BYTE_W-1:0] cmd);
        return cmd[CMD_ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI line, plus a history flop
// that turns transitions of the synchronized level into single-cycle pulses.
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        hist_d = sync_q[STAGES-1];
    end

    // No reset: the chain must keep tracking the pins while reset is held so
    // the FSM can see the true CS level when reset releases.
    always_ff @(posedge clk) begin
        sync_q <= sync_d;
        hist_q <= hist_d;
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~hist_q;
    assign fall = ~q & hist_q;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave frame receiver, oversampled in the clk_12mhz domain.
// Define SPI_MISO_EN to build the TX shifter that drives spi_miso.
module spi_frame_rx
    import spi_pkg::*;
#(
    parameter int FRAME_BYTES = FRAME_BYTES_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk_12mhz,
    input  logic                            reset,
    input  logic                            spi_clk,
    input  logic                            spi_mosi,
    input  logic                            spi_cs,
    output logic                            spi_miso,
    input  logic [SPI_BYTE_W-1:0]           tx_data,
    output logic [SPI_BYTE_W*FRAME_BYTES-1:0] frame_data,
    output logic                            frame_valid,
    output logic                            frame_err,
    output logic                            busy
);

    localparam int BCW = $clog2(FRAME_BYTES + 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(FRAME_BYTES - 1);

    logic sck_s, sck_rise, sck_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk_12mhz), .d(spi_clk), .q(sck_s), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk_12mhz), .d(spi_cs), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk_12mhz), .d(spi_mosi), .q(mosi_s),
        .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_state_e                              state_q, state_d;
    logic [2:0]                              bit_cnt_q, bit_cnt_d;
    logic [BCW-1:0]                          byte_cnt_q, byte_cnt_d;
    logic [SPI_BYTE_W-1:0]                   rx_q, rx_d;
    logic [FRAME_BYTES-1:0][SPI_BYTE_W-1:0]  buf_q, buf_d;
    logic                                    overrun_q, overrun_d;
    logic [2:0]                              vld_pipe_q, vld_pipe_d;
    logic [2:0]                              err_pipe_q, err_pipe_d;
    logic [SPI_BYTE_W*FRAME_BYTES-1:0]       frame_q, frame_d;
    logic                                    busy_q, busy_d;
    logic [SPI_BYTE_W-1:0]                   rx_byte;
    logic                                    dec_valid, dec_err;
    logic                                    tx_load, tx_shift;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        rx_d       = rx_q;
        buf_d      = buf_q;
        overrun_d  = overrun_q;
        frame_d    = frame_q;
        dec_valid  = 1'b0;
        dec_err    = 1'b0;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        rx_byte    = {rx_q[SPI_BYTE_W-2:0], mosi_s};

        // cs_rise is tested before sck_rise so a coincident SCK edge is dropped.
        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d    = SHIFT;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    overrun_d  = 1'b0;
                    tx_load    = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    dec_err = (bit_cnt_q != 3'd0) || (byte_cnt_q != '0);
                end else if (sck_rise) begin
                    rx_d      = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        buf_d[LAST_BYTE - byte_cnt_q] = rx_byte;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        tx_load    = 1'b1;
                        if (byte_cnt_q == LAST_BYTE)
                            state_d = FULL;
                    end
                end else if (sck_fall && bit_cnt_q != 3'd0) begin
                    // The fall after a byte's last rise keeps the freshly loaded MSB.
                    tx_shift = 1'b1;
                end
            end
            FULL: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    dec_valid = ~overrun_q;
                    dec_err   = overrun_q;
                end else if (sck_rise) begin
                    overrun_d = 1'b1;
                end
            end
            WAIT_CS: begin
                if (cs_rise)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Two extra stages align the strobes with SYNC_STAGES+2 cycles after CS is sampled high.
        vld_pipe_d = {vld_pipe_q[1:0], dec_valid};
        err_pipe_d = {err_pipe_q[1:0], dec_err};
        if (vld_pipe_q[1])
            frame_d = buf_q;
        busy_d = ~cs_s;
    end

    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            state_q    <= cs_s ? IDLE : WAIT_CS;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            rx_q       <= '0;
            buf_q      <= '0;
            overrun_q  <= 1'b0;
            vld_pipe_q <= '0;
            err_pipe_q <= '0;
            frame_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            rx_q       <= rx_d;
            buf_q      <= buf_d;
            overrun_q  <= overrun_d;
            vld_pipe_q <= vld_pipe_d;
            err_pipe_q <= err_pipe_d;
            frame_q    <= frame_d;
            busy_q     <= busy_d;
        end
    end

`ifdef SPI_MISO_EN
    logic [SPI_BYTE_W-1:0] tx_q, tx_d;

    always_comb begin
        tx_d = tx_q;
        if (tx_load)
            tx_d = tx_data;
        else if (tx_shift)
            tx_d = {tx_q[SPI_BYTE_W-2:0], 1'b0};
    end

    always_ff @(posedge clk_12mhz) begin
        if (reset)
            tx_q <= '0;
        else
            tx_q <= tx_d;
    end

    assign spi_miso = (state_q == SHIFT || state_q == FULL) && tx_q[SPI_BYTE_W-1];
`else
    logic tx_unused;
    assign tx_unused = ^{tx_data, tx_load, tx_shift};
    assign spi_miso  = 1'b0;
`endif

    assign frame_data  = frame_q;
    assign frame_valid = vld_pipe_q[2];
    assign frame_err   = err_pipe_q[2];
    assign busy        = busy_q;

endmodule
